jpeg_idct_block_arb: RTL and testbench

Block-granular round-robin arbiter sharing one IDCT input FIFO (push/accept interface, WIDTH-wide) between two coefficient producers (e.g. luma and chroma dequant paths).
Grants a requester ownership for exactly one whole block of BLOCK_SIZE samples, so blocks are never interleaved in the FIFO.
Tags each pushed sample with source id and end-of-block.
Sits between the dequantiser outputs and the IDCT input FIFO.

---
 rtl/jpeg_idct_block_arb_if.sv | 34 +++
 rtl/jpeg_idct_block_arb.sv | 102 ++++++++++
 tb/tb_jpeg_idct_block_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_idct_block_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jpeg_idct_block_arb_if                                        |
// | Brief    : Producer-side and FIFO-side handshake bundle of the arbiter.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface jpeg_idct_block_arb_if #(
    parameter int WIDTH = 16
);
    logic             in0_valid_i;
    logic [WIDTH-1:0] in0_data_i;
    logic             in0_accept_o;
    logic             in1_valid_i;
    logic [WIDTH-1:0] in1_data_i;
    logic             in1_accept_o;
    logic             out_push_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_id_o;
    logic             out_last_o;
    logic             out_accept_i;

    // Arbiter view.
    modport slave (
        input  in0_valid_i, in0_data_i, in1_valid_i, in1_data_i, out_accept_i,
        output in0_accept_o, in1_accept_o, out_push_o, out_data_o, out_id_o, out_last_o
    );

    // Environment view: producers and the downstream FIFO.
    modport master (
        output in0_valid_i, in0_data_i, in1_valid_i, in1_data_i, out_accept_i,
        input  in0_accept_o, in1_accept_o, out_push_o, out_data_o, out_id_o, out_last_o
    );
endinterface
`default_nettype wire

// File: rtl/jpeg_idct_block_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jpeg_idct_block_arb                                           |
// | Brief    : Block-granular round-robin arbiter feeding the IDCT FIFO.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module jpeg_idct_block_arb #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 64,
    parameter int CNT_W      = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    jpeg_idct_block_arb_if.slave  bus,
    output logic                  busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(BLOCK_SIZE - 1);

    state_t           r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_count;

    logic             w_kill;
    logic             w_active;
    logic             w_own_valid;
    logic [WIDTH-1:0] w_own_data;
    logic             w_at_last;
    logic             w_xfer;

    // Reset and flush also silence every output within the same cycle.
    assign w_kill      = rst_i | flush_i;
    assign w_active    = (r_state == ST_XFER) & ~w_kill;
    assign w_own_valid = r_owner ? bus.in1_valid_i : bus.in0_valid_i;
    assign w_own_data  = r_owner ? bus.in1_data_i  : bus.in0_data_i;
    assign w_at_last   = (r_count == c_last_idx);
    assign w_xfer      = w_active & w_own_valid & bus.out_accept_i;
    assign busy_o      = w_active;

    always_comb begin
        bus.out_push_o   = 1'b0;
        bus.out_data_o   = '0;
        bus.out_id_o     = 1'b0;
        bus.out_last_o   = 1'b0;
        bus.in0_accept_o = 1'b0;
        bus.in1_accept_o = 1'b0;
        if (w_active) begin
            bus.out_push_o   = w_own_valid;
            bus.out_data_o   = w_own_valid ? w_own_data : '0;
            bus.out_id_o     = r_owner;
            bus.out_last_o   = w_own_valid & w_at_last;
            bus.in0_accept_o = w_own_valid & ~r_owner & bus.out_accept_i;
            bus.in1_accept_o = w_own_valid &  r_owner & bus.out_accept_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_kill) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Contention goes to whoever was not granted last.
                    if (bus.in0_valid_i & bus.in1_valid_i) begin
                        r_owner <= ~r_last_grant;
                        r_state <= ST_XFER;
                    end else if (bus.in0_valid_i) begin
                        r_owner <= 1'b0;
                        r_state <= ST_XFER;
                    end else if (bus.in1_valid_i) begin
                        r_owner <= 1'b1;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_xfer) begin
                        if (w_at_last) begin
                            r_count      <= '0;
                            r_last_grant <= r_owner;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_idct_block_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jpeg_idct_block_arb                                        |
// | Brief    : Vector table, directed corner sequences and random traffic.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_jpeg_idct_block_arb;
    localparam int WIDTH = 16;
    localparam int BS    = 64;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst_i;
    logic flush_i;
    logic busy_o;

    always #5 clk = ~clk;

    jpeg_idct_block_arb_if #(.WIDTH(WIDTH)) bus ();

    jpeg_idct_block_arb #(
        .WIDTH(WIDTH), .BLOCK_SIZE(BS), .CNT_W(CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .flush_i(flush_i),
        .bus    (bus.slave),
        .busy_o (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: who owns the FIFO, how far into the block, who went last.
    bit m_busy  = 1'b0;
    bit m_owner = 1'b0;
    bit m_lastg = 1'b1;
    int m_cnt   = 0;

    int cyc_no, a0_cnt, a1_cnt, a0_first, a0_lastc, xfers, lasts, idles;
    int run_len = 0;
    int run_id  = 0;
    int grants[$];

    typedef struct {
        logic        rst, fl, v0, v1, acc;
        logic [15:0] d0, d1;
        logic [21:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] dut_out();
        return {bus.out_push_o, bus.out_id_o, bus.out_last_o, bus.in0_accept_o,
                bus.in1_accept_o, busy_o, bus.out_data_o};
    endfunction

    function automatic logic [21:0] model_out();
        logic        p;
        logic [15:0] d;
        if (rst_i || flush_i || !m_busy) return '0;
        p = m_owner ? bus.in1_valid_i : bus.in0_valid_i;
        d = m_owner ? bus.in1_data_i : bus.in0_data_i;
        return {p, m_owner, p && (m_cnt == BS - 1), p && !m_owner && bus.out_accept_i,
                p && m_owner && bus.out_accept_i, 1'b1, p ? d : 16'h0};
    endfunction

    task automatic model_step();
        bit v;
        v = m_owner ? bus.in1_valid_i : bus.in0_valid_i;
        if (rst_i || flush_i) begin
            m_busy = 0; m_cnt = 0; m_owner = 0; m_lastg = 1;
        end else if (!m_busy) begin
            if (bus.in0_valid_i && bus.in1_valid_i) begin m_owner = !m_lastg; m_busy = 1; end
            else if (bus.in0_valid_i) begin m_owner = 0; m_busy = 1; end
            else if (bus.in1_valid_i) begin m_owner = 1; m_busy = 1; end
        end else if (v && bus.out_accept_i) begin
            if (m_cnt == BS - 1) begin m_cnt = 0; m_lastg = m_owner; m_busy = 0; end
            else m_cnt++;
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v0, input logic v1, input logic acc);
        rst_i = r; flush_i = f;
        bus.in0_valid_i = v0; bus.in1_valid_i = v1; bus.out_accept_i = acc;
        bus.in0_data_i = 16'($urandom); bus.in1_data_i = 16'($urandom);
    endtask

    task automatic settle();
        #2;
        chk("cycle_outputs", 32'(dut_out()), 32'(model_out()));
        cyc_no++;
        if (bus.in0_accept_o) begin
            a0_cnt++;
            if (a0_first < 0) a0_first = cyc_no;
            a0_lastc = cyc_no;
        end
        if (bus.in1_accept_o) a1_cnt++;
        if (!bus.out_push_o) idles++;
        if (rst_i || flush_i) begin
            run_len = 0;
        end else if (bus.out_push_o && bus.out_accept_i) begin
            xfers++;
            if (run_len == 0) run_id = int'(bus.out_id_o);
            else chk("block_source", 32'(bus.out_id_o), 32'(run_id));
            run_len++;
            if (bus.out_last_o) begin
                lasts++;
                chk("block_length", 32'(run_len), 32'(BS));
                grants.push_back(int'(bus.out_id_o));
                run_len = 0;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic clear_stats();
        cyc_no = 0; a0_cnt = 0; a1_cnt = 0; a0_first = -1; a0_lastc = -1;
        xfers = 0; lasts = 0; idles = 0;
        grants.delete();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 1);
        cycle();
        clear_stats();
    endtask

    task automatic run(input int n, input logic v0, input logic v1, input logic acc);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, v0, v1, acc);
            cycle();
        end
    endtask

    function automatic int grant_at(input int i);
        return (grants.size() > i) ? grants[i] : -1;
    endfunction

    vec_t vecs[10];

    initial begin
        int saved;
        clear_stats();

        // Fields: rst fl v0 v1 acc d0 d1 | {push,id,last,a0,a1,busy,data}
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 22'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 22'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 22'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, {6'b100101, 16'h1234}};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, {6'b000001, 16'h0000}};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0F0F, 16'hBEEF, {6'b100001, 16'h0F0F}};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 16'hBEEF, 22'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 22'h0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, {6'b110011, 16'hBEEF}};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 22'h0};

        for (int i = 0; i < 10; i++) begin
            rst_i = vecs[i].rst; flush_i = vecs[i].fl;
            bus.in0_valid_i = vecs[i].v0; bus.in1_valid_i = vecs[i].v1;
            bus.out_accept_i = vecs[i].acc;
            bus.in0_data_i = vecs[i].d0; bus.in1_data_i = vecs[i].d1;
            settle();
            chk($sformatf("vector_%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
            advance();
        end

        // Requester 0 alone for one block.
        do_reset();
        run(65, 1'b1, 1'b0, 1'b1);
        chk("solo_accept_count", 32'(a0_cnt), 32'd64);
        chk("solo_first_accept_cycle", 32'(a0_first), 32'd2);
        chk("solo_last_accept_cycle", 32'(a0_lastc), 32'd65);
        chk("solo_last_count", 32'(lasts), 32'd1);
        chk("solo_busy_after", 32'(busy_o), 32'd0);

        // Both requesters saturating: grants alternate.
        do_reset();
        run(4 * (BS + 1), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_grant_%0d", i), 32'(grant_at(i)), 32'(i % 2));
        chk("alt_idle_cycles", 32'(idles), 32'd4);
        chk("alt_transfers", 32'(xfers), 32'(4 * BS));

        // FIFO backpressure with owner 1 at sample 10.
        do_reset();
        run(11, 1'b0, 1'b1, 1'b1);
        chk("bp_pre_count", 32'(xfers), 32'd10);
        saved = a1_cnt;
        run(5, 1'b0, 1'b1, 1'b0);
        chk("bp_stall_transfers", 32'(xfers), 32'd10);
        chk("bp_stall_accepts", 32'(a1_cnt - saved), 32'd0);
        run(54, 1'b0, 1'b1, 1'b1);
        chk("bp_total", 32'(xfers), 32'(BS));
        chk("bp_last", 32'(lasts), 32'd1);

        // Owner 0 pauses while requester 1 waits.
        do_reset();
        run(20, 1'b1, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1, 1'b1);
        run(45, 1'b1, 1'b1, 1'b1);
        chk("gap_no_req1", 32'(a1_cnt), 32'd0);
        chk("gap_block0_done", 32'(lasts), 32'd1);
        run(BS + 1, 1'b1, 1'b1, 1'b1);
        chk("gap_next_grant", 32'(grant_at(1)), 32'd1);

        // Flush mid-block, owner 0.
        do_reset();
        run(31, 1'b1, 1'b1, 1'b1);
        drive(0, 1, 1, 1, 1);
        cycle();
        chk("flush_no_last", 32'(lasts), 32'd0);
        chk("flush_idle", 32'(busy_o), 32'd0);
        clear_stats();
        run(2, 1'b1, 1'b1, 1'b1);
        chk("flush_regrant_id", 32'(run_id), 32'd0);
        run(63, 1'b1, 1'b1, 1'b1);
        chk("flush_block_done", 32'(grant_at(0)), 32'd0);

        // Reset mid-block at sample 50.
        do_reset();
        run(51, 1'b1, 1'b0, 1'b1);
        drive(1, 0, 1, 1, 1);
        cycle();
        chk("rst_outputs_zero", 32'(dut_out()), 32'd0);
        clear_stats();
        run(65, 1'b1, 1'b0, 1'b1);
        chk("rst_fresh_transfers", 32'(xfers), 32'(BS));
        chk("rst_fresh_last", 32'(lasts), 32'd1);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) != 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
